// File: rtl/cic_agc.sv
// cic_agc: automatic gain controller for the CIC decimator.
//
// Tracks the peak magnitude of the decimated stream over windows of WINDOW
// output samples. After each window it steps `gain` by one code, using
// hysteresis between LO_THRESH and HI_THRESH. Each step is followed by a
// holdoff of HOLDOFF output samples while the comb pipeline settles. With
// `enable` low, `gain` follows `manual_gain`, clamped to GAIN_MAX.
//
// Optional feature macro: CIC_AGC_FAST_ATTACK_EN
//   When defined, a clipped sample seen in MEASURE (with gain > 0) lowers the
//   gain immediately and abandons the current window.
//
// Ports:
//   CLK          clock
//   RSTb         synchronous active-low reset
//   x_in         signed decimator output sample
//   in_tick      decimator output strobe (never on consecutive cycles)
//   enable       1 = automatic gain, 0 = manual gain
//   manual_gain  gain used while enable = 0
//   gain         gain code to the decimator
//   gain_step    one-cycle pulse when the AGC changes gain
//   peak         peak magnitude of the last completed window
//   peak_valid   one-cycle pulse when peak is updated
module cic_agc #(
  parameter int              BITS      = 16,
  parameter int              GAIN_BITS = 8,
  parameter int              GAIN_MAX  = 8,
  parameter int              GAIN_INIT = 0,
  parameter int              WINDOW    = 1024,
  parameter int              HOLDOFF   = 8,
  parameter logic [BITS-1:0] HI_THRESH = 16'h6000,
  parameter logic [BITS-1:0] LO_THRESH = 16'h1800
) (
  input  logic                  CLK,
  input  logic                  RSTb,
  input  logic signed [BITS-1:0] x_in,
  input  logic                  in_tick,
  input  logic                  enable,
  input  logic [GAIN_BITS-1:0]  manual_gain,
  output logic [GAIN_BITS-1:0]  gain,
  output logic                  gain_step,
  output logic [BITS-1:0]       peak,
  output logic                  peak_valid
);

  localparam int CNT_MAX = (WINDOW > HOLDOFF) ? WINDOW : HOLDOFF;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]        WIN_LAST  = CW'(WINDOW - 1);
  localparam logic [CW-1:0]        HOLD_LAST = CW'(HOLDOFF - 1);
  localparam logic [GAIN_BITS-1:0] G_MAX     = GAIN_BITS'(GAIN_MAX);
  localparam logic [GAIN_BITS-1:0] G_INIT    = GAIN_BITS'(GAIN_INIT);
  localparam logic [GAIN_BITS-1:0] G_ONE     = GAIN_BITS'(1);
  localparam logic [CW-1:0]        C_ONE     = CW'(1);
  localparam logic [BITS-1:0]      MAG_MAX   = {1'b0, {(BITS-1){1'b1}}};
  localparam logic [BITS-1:0]      NEG_FULL  = {1'b1, {(BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    DECIDE,
    HOLD
  } state_t;

  state_t                 state;
  logic [BITS-1:0]        run_peak;
  logic [CW-1:0]          win_cnt;
  logic [CW-1:0]          hold_cnt;

  logic [BITS-1:0]        mag;
  logic [BITS-1:0]        peak_next;
  logic [GAIN_BITS-1:0]   manual_clamped;
  logic                   clipped;

  // Saturating magnitude: the most negative code maps to the largest positive one.
  always_comb begin
    mag = $unsigned(x_in);
    if (x_in[BITS-1]) begin
      if ($unsigned(x_in) == NEG_FULL) begin
        mag = MAG_MAX;
      end else begin
        mag = $unsigned(-x_in);
      end
    end
    peak_next      = (mag > run_peak) ? mag : run_peak;
    manual_clamped = (manual_gain > G_MAX) ? G_MAX : manual_gain;
    clipped        = (mag == MAG_MAX);
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state      <= IDLE;
      gain       <= G_INIT;
      gain_step  <= 1'b0;
      peak       <= '0;
      peak_valid <= 1'b0;
      run_peak   <= '0;
      win_cnt    <= '0;
      hold_cnt   <= '0;
    end else begin
      gain_step  <= 1'b0;
      peak_valid <= 1'b0;
      if (!enable) begin
        // Manual mode from any state: abandon partial window/holdoff.
        state    <= IDLE;
        gain     <= manual_clamped;
        run_peak <= '0;
        win_cnt  <= '0;
        hold_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= MEASURE;
          end

          MEASURE: begin
            if (in_tick) begin
`ifdef CIC_AGC_FAST_ATTACK_EN
              if (clipped && (gain != '0)) begin
                gain      <= gain - G_ONE;
                gain_step <= 1'b1;
                run_peak  <= '0;
                win_cnt   <= '0;
                hold_cnt  <= '0;
                state     <= HOLD;
              end else
`endif
              if (win_cnt == WIN_LAST) begin
                peak       <= peak_next;
                peak_valid <= 1'b1;
                run_peak   <= '0;
                win_cnt    <= '0;
                state      <= DECIDE;
              end else begin
                run_peak <= peak_next;
                win_cnt  <= win_cnt + C_ONE;
              end
            end
          end

          // Single cycle; any in_tick arriving here is intentionally dropped.
          DECIDE: begin
            hold_cnt <= '0;
            if ((peak >= HI_THRESH) && (gain != '0)) begin
              gain      <= gain - G_ONE;
              gain_step <= 1'b1;
              state     <= HOLD;
            end else if ((peak < LO_THRESH) && (gain < G_MAX)) begin
              gain      <= gain + G_ONE;
              gain_step <= 1'b1;
              state     <= HOLD;
            end else begin
              state <= MEASURE;
            end
          end

          HOLD: begin
            if (in_tick) begin
              if (hold_cnt == HOLD_LAST) begin
                hold_cnt <= '0;
                state    <= MEASURE;
              end else begin
                hold_cnt <= hold_cnt + C_ONE;
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Only referenced when the fast-attack path is built in.
  logic unused_clipped;
  assign unused_clipped = clipped;

endmodule

// File: doc/cic_agc.md
# cic_agc

Automatic gain controller for the CIC decimator. It watches the decimated output stream (`x_out` / `out_tick`) and measures the peak magnitude over fixed windows of output samples. It then steps the decimator's `gain` input up or down by one bit, with hysteresis, and waits a holdoff period after each change while the comb pipeline settles. When disabled it passes a manual gain through, so software keeps full control.

## Interface
Parameters:
- `BITS`, 16: sample width; matches the decimator `BITS`.
- `GAIN_BITS`, 8: gain word width; matches the decimator `GAIN_BITS`.
- `GAIN_MAX`, 8: highest legal gain code. Must be ≤ `WIDTH-BITS-2` of the decimator.
- `GAIN_INIT`, 0: gain code loaded at reset.
- `WINDOW`, 1024: output samples per measurement window, ≥ 1.
- `HOLDOFF`, 8: output samples ignored after any gain change, ≥ 1.
- `HI_THRESH`, 16'h6000: peak ≥ this requests gain−1.
- `LO_THRESH`, 16'h1800: peak < this requests gain+1. Required: 2·`LO_THRESH` < `HI_THRESH`.

Ports:
- `CLK` in 1: clock.
- `RSTb` in 1: reset, synchronous, active-low.
- `x_in` in `BITS` signed: decimator `x_out`.
- `in_tick` in 1: decimator `out_tick`; one-cycle strobe, never on consecutive cycles.
- `enable` in 1: 1 = automatic mode, 0 = manual mode.
- `manual_gain` in `GAIN_BITS`: gain used while `enable`=0.
- `gain` out `GAIN_BITS` reg: drives the decimator `gain`.
- `gain_step` out 1 reg: one-cycle pulse when AGC changes `gain`.
- `peak` out `BITS` reg: peak magnitude of the last completed window.
- `peak_valid` out 1 reg: one-cycle pulse when `peak` is updated.

## Operation
- Magnitude is |`x_in`|, saturated: −2^(`BITS`−1) maps to 2^(`BITS`−1)−1. Comparisons are unsigned on the magnitude.
- State machine: IDLE, MEASURE, DECIDE, HOLD.
- **IDLE**
  - Every cycle: `gain` ← min(`manual_gain`, `GAIN_MAX`). Window counter, hold counter and running peak are cleared.
  - `enable`=1 → MEASURE, with `gain` keeping its current value.
- **MEASURE**
  - Each `in_tick`: running peak ← max(running peak, magnitude); window count +1.
  - On the `WINDOW`-th tick:
    - `peak` ← final max, including that sample.
    - Running peak and count are cleared.
    - → DECIDE.
- **DECIDE** (exactly 1 cycle; `peak_valid`=1 during it)
  - If `peak` ≥ `HI_THRESH` and `gain`>0: `gain`−1, `gain_step`, → HOLD.
  - Else if `peak` < `LO_THRESH` and `gain`<`GAIN_MAX`: `gain`+1, `gain_step`, → HOLD.
  - Otherwise → MEASURE, with no change.
  - An `in_tick` arriving during DECIDE is dropped and is not counted in any window.
- **HOLD**
  - Counts `in_tick`s. Samples are not measured.
  - After the `HOLDOFF`-th tick → MEASURE with a fresh window.
- `enable`=0 in any state → IDLE on the next edge. Any partial window or holdoff is abandoned, and no `peak_valid` is generated.
- `gain` never leaves the range 0..`GAIN_MAX`. Saturation at either end means no step and no `gain_step`.

## Timing
- Reset values:
  - `gain` = `GAIN_INIT`
  - `peak` = 0
  - `peak_valid` = 0
  - `gain_step` = 0
  - state = IDLE
  - all counters = 0
- Reset mid-window or mid-holdoff discards everything on the same edge.
- Window close: the edge that samples the `WINDOW`-th tick (E0) updates `peak`. `peak_valid` is high for the cycle after E0.
- The next edge (E1) updates `gain`. `gain_step` is high for the cycle after E1.
- Latency from final sampled tick to new `gain` is 2 clocks.
- Manual mode: `gain` follows `manual_gain` with 1 clock latency.
- Counter widths are $clog2(max(`WINDOW`,`HOLDOFF`)+1). Counters never wrap, because the terminal count is detected explicitly.

## Configuration
- `CIC_AGC_FAST_ATTACK_EN` defined:
  - In MEASURE, a tick whose magnitude equals 2^(`BITS`−1)−1 (a clipped sample), while `gain`>0, acts immediately: on the next edge `gain`−1, `gain_step` pulses, and the state goes → HOLD.
  - The current window is discarded and no `peak_valid` is generated.
  - If `gain`=0, the clipped sample is only accumulated into the peak.
- `CIC_AGC_FAST_ATTACK_EN` undefined: clipped samples only contribute to the peak. All gain decisions happen in DECIDE.

## Test plan
- Reset with `GAIN_INIT`=3, `enable`=0, `manual_gain`=12, `GAIN_MAX`=8 → `gain`=3 during reset, then 8 one clock after release; no pulses.
- `enable`=1, `WINDOW`=16, `gain`=4, 16 ticks of constant +16'h7000 → `peak`=16'h7000 with `peak_valid`; `gain`=3 with `gain_step` one clock later; the next 8 ticks (HOLD) change nothing.
- Ticks of 16'h1000 and −16'h1000, starting at `gain`=6 → `gain` steps +1 per window (each followed by holdoff) until it reaches 8, then stays at 8 with no `gain_step`.
- Window whose peak is a single sample of −32768 → `peak`=16'h7FFF. A steady peak of 16'h3000 → no change, and the next window starts with no holdoff.
- `enable` dropped after 10 ticks of a 16-tick window → IDLE next edge, no `peak_valid`, `gain`=`manual_gain`. Re-enable → a full 16 fresh ticks are needed before DECIDE.
- With `CIC_AGC_FAST_ATTACK_EN` defined, `gain`=5 and the 3rd window tick = 16'h7FFF → `gain`=4 with `gain_step` one clock later, no `peak_valid`, HOLD entered. Without the macro → no change until the window closes.
